// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready handshake, synchronous flush,
// bubble (zero-ctrl) insertion, optional 2-entry skid buffer for a registered ready.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 5,
   parameter int unsigned SKID   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occ
);

   logic              main_v_q, main_v_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              skid_v_q, skid_v_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [1:0]        occ_q, occ_d;
   logic              push, pop;

   generate
      if (SKID != 0) begin : g_skid
         assign in_ready = !skid_v_q && !flush;
      end else begin : g_noskid
         assign in_ready = !flush && (!main_v_q || out_ready);
      end
   endgenerate

   assign push = in_valid && in_ready;
   assign pop  = main_v_q && out_ready;

   // main_ctrl_q is kept at zero whenever main is empty, so out_ctrl needs no gating
   always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         main_v_d    = 1'b0;
         main_ctrl_d = '0;
         skid_v_d    = 1'b0;
      end else begin
         if (pop) begin
            if (skid_v_q) begin
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
               skid_v_d    = 1'b0;
            end else begin
               main_v_d    = 1'b0;
               main_ctrl_d = '0;
            end
         end
         if (push) begin
            if (!main_v_d) begin
               main_v_d    = 1'b1;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else begin
               skid_v_d    = 1'b1;
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
            end
         end
      end
      occ_d = 2'(main_v_d) + 2'(skid_v_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_v_q    <= 1'b0;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         occ_q       <= 2'd0;
      end else begin
         main_v_q    <= main_v_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         occ_q       <= occ_d;
      end
   end

   assign out_valid = main_v_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;
   assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 instance with shared stimulus and checks both
// against queue-based reference models.
module tb_pipe_stage_reg;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 5;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   logic          rdy1, vld1, rdy0, vld0;
   logic [DW-1:0] data1, data0;
   logic [CW-1:0] ctrl1, ctrl0;
   logic [1:0]    occ1, occ0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(vld1), .out_ready(out_ready), .out_data(data1), .out_ctrl(ctrl1),
      .occ(occ1));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(vld0), .out_ready(out_ready), .out_data(data0), .out_ctrl(ctrl0),
      .occ(occ0));

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   ent_t          q1[$];
   ent_t          q0[$];
   logic [DW-1:0] last1, last0;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_rdy1();
      return !flush && (q1.size() < 2);
   endfunction

   function automatic logic exp_rdy0();
      return !flush && ((q0.size() == 0) || out_ready);
   endfunction

   task automatic check_outs();
      check("s1_in_ready",  64'(rdy1),  64'(exp_rdy1()));
      check("s1_out_valid", 64'(vld1),  64'(q1.size() > 0));
      check("s1_out_data",  64'(data1), 64'(last1));
      check("s1_out_ctrl",  64'(ctrl1), 64'((q1.size() > 0) ? q1[0].c : '0));
      check("s1_occ",       64'(occ1),  64'(q1.size()));
      check("s0_in_ready",  64'(rdy0),  64'(exp_rdy0()));
      check("s0_out_valid", 64'(vld0),  64'(q0.size() > 0));
      check("s0_out_data",  64'(data0), 64'(last0));
      check("s0_out_ctrl",  64'(ctrl0), 64'((q0.size() > 0) ? q0[0].c : '0));
      check("s0_occ",       64'(occ0),  64'(q0.size()));
   endtask

   task automatic clear_models();
      q1.delete();
      q0.delete();
      last1 = '0;
      last0 = '0;
   endtask

   // FIFO semantics of one rising edge: flush kills everything, otherwise pop then push
   task automatic model_edge();
      logic push1, pop1, push0, pop0;
      ent_t e;
      if (reset) begin
         clear_models();
      end else begin
         push1 = in_valid && exp_rdy1();
         pop1  = (q1.size() > 0) && out_ready;
         push0 = in_valid && exp_rdy0();
         pop0  = (q0.size() > 0) && out_ready;
         e.d = in_data;
         e.c = in_ctrl;
         if (flush) begin
            q1.delete();
            q0.delete();
         end else begin
            if (pop1) void'(q1.pop_front());
            if (push1) q1.push_back(e);
            if (pop0) void'(q0.pop_front());
            if (push0) q0.push_back(e);
         end
         if (q1.size() > 0) last1 = q1[0].d;
         if (q0.size() > 0) last0 = q0[0].d;
      end
   endtask

   task automatic step(input logic fl, input logic iv, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic ordy);
      @(negedge clk);
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      #1;
      check_outs();
      @(posedge clk);
      model_edge();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      clear_models();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_outs();
      reset = 1'b0;

      // stream with a one-cycle bubble in the middle
      step(0, 1, 32'h10, 5'b10101, 1);
      step(0, 1, 32'h11, 5'b10101, 1);
      step(0, 0, 32'h0,  5'b11111, 1);
      step(0, 1, 32'h12, 5'b10101, 1);
      step(0, 0, 32'h0,  5'b0,     1);
      step(0, 0, 32'h0,  5'b0,     1);

      // backpressure fill, then drain
      step(0, 1, 32'hA0, 5'b00011, 0);
      step(0, 1, 32'hA1, 5'b00101, 0);
      step(0, 1, 32'hA2, 5'b01001, 0);
      step(0, 1, 32'hA2, 5'b01001, 1);
      step(0, 1, 32'hA2, 5'b01001, 1);
      step(0, 0, 32'h0,  5'b0,     1);
      step(0, 0, 32'h0,  5'b0,     1);

      // flush with full buffer and a live input
      step(0, 1, 32'hC0, 5'b00001, 0);
      step(0, 1, 32'hC1, 5'b00010, 0);
      step(1, 1, 32'hBB, 5'b11011, 0);
      step(0, 0, 32'h0,  5'b0,     1);
      step(0, 0, 32'h0,  5'b0,     1);

      // asynchronous reset between edges with occ=2
      step(0, 1, 32'hD0, 5'b00110, 0);
      step(0, 1, 32'hD1, 5'b01100, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      reset = 1'b1;
      clear_models();
      #1;
      check_outs();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      reset = 1'b0;
      step(0, 1, 32'h55, 5'b10001, 0);
      step(0, 1, 32'h56, 5'b10010, 1);
      step(0, 0, 32'h0,  5'b0,     1);
      step(0, 0, 32'h0,  5'b0,     1);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0),
              DW'($urandom),
              CW'($urandom),
              ($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register that replaces the fixed per-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with one generic block.
- Carries a DATA_W-bit payload and a CTRL_W-bit control bundle between two pipeline stages.
- Uses a valid/ready handshake, a synchronous flush, and automatic bubble (all-zero control) insertion.
- Has an optional 2-entry skid buffer, so in_ready is fully registered and stalls do not form long combinational ready chains.

Parameters:
DATA_W, 32, payload width (ALU result, write address, funct3, etc. packed by the instantiator)
CTRL_W, 5, control bundle width (RDSrc, MemtoReg, MemWrite, MemRead, RegWrite, ...); forced to 0 on bubbles
SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all held entries and of this cycle's input
in_valid  input  1  upstream stage presents an entry
in_ready  output  1  stage can accept an entry this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bundle
out_valid  output  1  out_data/out_ctrl hold a live entry
out_ready  input  1  downstream stage consumes the entry this cycle
out_data  output  DATA_W  payload of the oldest entry
out_ctrl  output  CTRL_W  control bundle of the oldest entry; 0 when out_valid=0
occ  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Reset (async, active-high):
  - all entry valid bits = 0; main/skid data = 0 and ctrl = 0
  - outputs: out_valid=0, out_data=0, out_ctrl=0, occ=0
  - in_ready after reset: 1 when SKID=1; 1 when SKID=0 (out_valid=0)
- Transfer rules:
  - input transfer = in_valid & in_ready
  - output transfer = out_valid & out_ready
  - all state updates on rising clk
- Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N; there is no combinational path from in_* to out_*.
- Bubble: whenever out_valid=0, out_ctrl is forced to 0 (downstream sees a NOP). out_data holds its last value (don't-care).
- SKID=0:
  - in_ready = !flush & (!out_valid | out_ready)
  - on input transfer, main is loaded
  - on output transfer without input transfer, main valid clears
- SKID=1: entries are main (drives out_*) and skid.
  - in_ready = !skid_valid & !flush; skid_valid is registered
  - Pop: on output transfer, if skid_valid then skid→main (skid clears), else main valid clears.
  - Push: on input transfer, the entry goes to main if main ends the cycle empty (empty, or popped with skid empty); otherwise it goes to skid.
  - Simultaneous push + pop with skid empty: main is replaced by the new entry; occ unchanged.
  - Full (occ=2): in_ready=0. A pop moves skid→main, and in_ready rises the next cycle.
  - FIFO order is always preserved; no entry is lost or duplicated.
- flush:
  - has priority over everything: at the edge, all valid bits clear, occ=0
  - in_ready=0 during a flush cycle, so no input is accepted
  - an output transfer in the flush cycle is still counted by downstream (flush does not retract the current out_valid before the edge)
- occ = main_valid + skid_valid, registered.
- Reset mid-operation: all entries are dropped immediately (async), regardless of the handshake state.
- Widths: payload and control pass through unchanged (no arithmetic). DATA_W ≥ 1, CTRL_W ≥ 1.

Test Plan:
- Reset then stream: SKID=1, in_valid=1 with in_data=0x10,0x11,0x12 on consecutive cycles, out_ready=1 → out_data 0x10,0x11,0x12 one cycle later; occ stays 1; out_ctrl equals in_ctrl (e.g. 5'b10101).
- Backpressure fill: out_ready=0, push 0xA0 then 0xA1 → occ=2, in_ready=0 after the second push, 0xA2 held off upstream. Then out_ready=1 → outputs 0xA0, 0xA1, 0xA2 in order; in_ready returns 1 one cycle after the first pop.
- Bubble: in_valid=0 for one cycle inside the stream → out_valid=0 and out_ctrl=0 that cycle, while out_data retains its previous value.
- Flush: occ=2, flush=1 with in_valid=1 and in_data=0xBB → next cycle occ=0, out_valid=0, out_ctrl=0; 0xBB never appears.
- Async reset mid-stream: assert reset between edges with occ=2 → out_valid, occ and out_ctrl go to 0 without waiting for a clk edge; the first push after deassertion is output first.
- SKID=0 instance: out_ready=0 with out_valid=1 → in_ready=0 the same cycle; out_ready=1 with in_valid=1 → back-to-back transfers at full throughput.
